array_fill_sequencer: RTL and testbench
=======================================

// Module: array_fill_sequencer
// PURPOSE
//  Clocked fill-and-verify engine that sits directly upstream of the register array.
//  It drives the array's index/writeData/writeEnable port and sweeps every entry
//  with a selectable data pattern. It can then read each entry back through the
//  same index port and compare it. It reports pass/fail, the first failing index
//  and the mismatch count. It replaces ad-hoc delay-driven init loops.
// PARAMETERS
//  DEPTH   32  number of array entries swept (index 0..DEPTH-1)
//  IDX_W   6   index width; must satisfy 2**IDX_W >= DEPTH
//  DATA_W  32  data width
// PORTS
//  clk          in   1       single clock; all state changes on posedge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       start a sweep; sampled only in IDLE
//  abort        in   1       synchronous abort; return to IDLE; no done pulse
//  pattern_sel  in   2       0:idx+base 1:base 2:~(idx+base) 3:base rotl idx[4:0]
//  base_value   in   DATA_W  pattern seed
//  skip_verify  in   1       1 = fill only
//  index        out  IDX_W   array index (registered)
//  writeData    out  DATA_W  array write data (registered)
//  writeEnable  out  1       array write strobe (registered)
//  readData     in   DATA_W  array read data for the index driven last cycle
//  busy         out  1       high in FILL and VERIFY
//  done         out  1       one-cycle pulse at sweep completion
//  pass         out  1       result: 1 = zero mismatches; holds until next start
//  err_index    out  IDX_W   index of first mismatch; 0 when pass
//  err_count    out  IDX_W+1 mismatch count, max DEPTH; holds until next start
// BEHAVIOUR
//  Reset: state IDLE. All outputs are 0, including index, writeData, writeEnable,
//   busy, done, pass, err_index and err_count.
//  FSM states: IDLE -> FILL -> VERIFY -> DONE -> IDLE.
//   If skip_verify=1, the sequence is FILL -> DONE.
//  IDLE: start=1 latches pattern_sel, base_value and skip_verify, then clears
//   pass, err_index and err_count. The next cycle enters FILL.
//  FILL: lasts exactly DEPTH cycles.
//   - Cycle k drives index=k, writeData=pat(k) and writeEnable=1.
//   - After k=DEPTH-1, writeEnable=0 on the following cycle.
//   - Pattern arithmetic is modulo 2**DATA_W; idx is zero-extended.
//  VERIFY: lasts DEPTH+1 cycles. writeEnable stays 0.
//   - Cycle k (k<DEPTH) drives index=k.
//   - Cycle k+1 compares readData with pat(k).
//   - A mismatch increments err_count. The first mismatch records err_index.
//   - During the final compare cycle, index holds DEPTH-1.
//  DONE: lasts one cycle. done=1 and busy=0.
//   - pass=1 when err_count==0.
//   - With skip_verify=1: pass=1 and err_count=0.
//   - Then returns to IDLE and index returns to 0.
//  start while busy or in DONE: ignored; no restart or queueing.
//  abort (FILL/VERIFY): next cycle is IDLE with writeEnable=0, busy=0, done=0.
//   pass, err_index and err_count are left as they are.
//   A partial fill is not rolled back.
//  abort and start in the same IDLE cycle: abort wins; the block stays in IDLE.
//  rst mid-sweep: identical to reset. It overrides abort and start.
//  Wrap: index never exceeds DEPTH-1. With DEPTH < 2**IDX_W, the unused upper
//   index values are never driven.
// TESTING
//  1. rst, then start with pattern_sel=0, base=0, skip_verify=1 -> 32 writes,
//     index 0..31 and writeData 0..31. done fires 33 cycles after start; pass=1.
//  2. Model array ideal, pattern_sel=2, base=0x10 -> 32 writes with data ~(k+0x10).
//     pass=1, err_count=0, done 66 cycles after start.
//  3. Corrupt entries 5 and 17 in the model -> pass=0, err_index=5, err_count=2.
//  4. Assert abort at FILL cycle 10 -> writeEnable=0 next cycle and busy=0.
//     No done pulse. A new start then completes normally.
//  5. Pulse start during FILL and during DONE -> no effect on that sweep.
//     Exactly one done pulse.
//  6. rst mid-VERIFY -> next cycle all outputs 0 and state IDLE.
//     pattern_sel=3, base=0x1 then gives writeData=(1<<k) for k<32.

Source files
------------

// File: rtl/array_fill_sequencer.sv
// Fill-and-verify sequencer for the register array: sweeps every entry with a
// selectable pattern, optionally reads each entry back and reports mismatches.
module array_fill_sequencer #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] base_value,
  input  logic              skip_verify,
  output logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  input  logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  err_index,
  output logic [IDX_W:0]    err_count
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

  localparam logic [IDX_W:0] CNT_LAST  = (IDX_W+1)'(DEPTH - 1);
  localparam logic [IDX_W:0] CNT_DEPTH = (IDX_W+1)'(DEPTH);

  state_t              state_q;
  logic [1:0]          sel_q;
  logic [DATA_W-1:0]   base_q;
  logic                skip_q;
  logic [IDX_W:0]      cnt_q;
  logic [IDX_W-1:0]    index_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [IDX_W-1:0]    err_index_q;
  logic [IDX_W:0]      err_count_q;

  logic [IDX_W:0]      cnt_inc;
  logic [IDX_W-1:0]    cmp_idx;
  logic                mism;
  logic [IDX_W:0]      err_count_d;

  function automatic logic [DATA_W-1:0] pat(input logic [1:0]        sel,
                                            input logic [DATA_W-1:0] base,
                                            input logic [IDX_W:0]    k);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] rot;
    int unsigned       sh;
    sum = base + DATA_W'(k);
    sh  = {27'd0, k[4:0]} % DATA_W;
    rot = (sh == 0) ? base : ((base << sh) | (base >> (DATA_W - sh)));
    case (sel)
      2'd0:    pat = sum;
      2'd1:    pat = base;
      2'd2:    pat = ~sum;
      default: pat = rot;
    endcase
  endfunction

  // Read data arriving in VERIFY cycle k belongs to the index driven in cycle k-1.
  always_comb begin
    cnt_inc     = cnt_q + (IDX_W+1)'(1);
    cmp_idx     = cnt_q[IDX_W-1:0] - IDX_W'(1);
    mism        = (state_q == S_VERIFY) && (cnt_q != '0) &&
                  (readData != pat(sel_q, base_q, {1'b0, cmp_idx}));
    err_count_d = err_count_q + (IDX_W+1)'(mism);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      base_q      <= '0;
      skip_q      <= 1'b0;
      cnt_q       <= '0;
      index_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_index_q <= '0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            sel_q       <= pattern_sel;
            base_q      <= base_value;
            skip_q      <= skip_verify;
            pass_q      <= 1'b0;
            err_index_q <= '0;
            err_count_q <= '0;
            cnt_q       <= '0;
            index_q     <= '0;
            wdata_q     <= pat(pattern_sel, base_value, '0);
            we_q        <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            we_q  <= 1'b0;
            cnt_q <= '0;
            if (skip_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              index_q <= '0;
              state_q <= S_VERIFY;
            end
          end else begin
            cnt_q   <= cnt_inc;
            index_q <= cnt_inc[IDX_W-1:0];
            wdata_q <= pat(sel_q, base_q, cnt_inc);
          end
        end
        S_VERIFY: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            err_count_q <= err_count_d;
            if (mism && (err_count_q == '0))
              err_index_q <= cmp_idx;
            if (cnt_q == CNT_DEPTH) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_q != CNT_LAST)
                index_q <= cnt_inc[IDX_W-1:0];
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          index_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign index       = index_q;
  assign writeData   = wdata_q;
  assign writeEnable = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_index   = err_index_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_array_fill_sequencer.sv
// Bench for array_fill_sequencer: a synchronous-read array model with optional
// corrupted entries, a vector table of whole sweeps, and hand-written corner cases.
module tb_array_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, skip_verify;
  logic [1:0]  pattern_sel;
  logic [31:0] base_value, writeData, readData;
  logic [5:0]  index, err_index;
  logic [6:0]  err_count;
  logic        writeEnable, busy, done, pass;

  array_fill_sequencer #(.DEPTH(32), .IDX_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .base_value(base_value), .skip_verify(skip_verify),
    .index(index), .writeData(writeData), .writeEnable(writeEnable),
    .readData(readData), .busy(busy), .done(done), .pass(pass),
    .err_index(err_index), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Array model: entries flagged in corrupt store data with bit 0 flipped.
  logic [31:0] mem [64];
  logic [31:0] corrupt;
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (writeEnable) mem[index] <= writeData ^ {31'd0, corrupt[index[4:0]]};
    rd_q <= mem[index];
  end
  assign readData = rd_q;

  logic [5:0]  wr_idx [64];
  logic [31:0] wr_dat [64];
  int          wr_n;
  always @(negedge clk) begin
    if (writeEnable && wr_n < 64) begin
      wr_idx[wr_n] = index;
      wr_dat[wr_n] = writeData;
      wr_n++;
    end
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] base;
    logic        skip;
    logic [31:0] corrupt;
    int          lat;
    logic        pass;
    logic [5:0]  ei;
    logic [6:0]  ec;
    logic [31:0] wd3;
    logic [31:0] wd31;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pat(input logic [1:0] sel, input logic [31:0] base, input int k);
    logic [63:0] dbl;
    logic [31:0] s;
    s   = base + 32'(k);
    dbl = {base, base} << (k % 32);
    case (sel)
      2'd0:    return s;
      2'd1:    return base;
      2'd2:    return ~s;
      default: return dbl[63:32];
    endcase
  endfunction

  task automatic run_sweep(input logic [1:0] sel, input logic [31:0] base, input logic skip,
                           output int lat);
    wr_n = 0;
    lat  = -1;
    @(negedge clk);
    pattern_sel = sel; base_value = base; skip_verify = skip; start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_row(input vec_t v, input string tag);
    int lat;
    int bad;
    corrupt = v.corrupt;
    run_sweep(v.sel, v.base, v.skip, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'(v.pass));
    chk({tag, "_err_index"}, 64'(err_index), 64'(v.ei));
    chk({tag, "_err_count"}, 64'(err_count), 64'(v.ec));
    bad = (wr_n == 32) ? 0 : 100;
    for (int i = 0; i < wr_n; i++)
      if (wr_idx[i] !== 6'(i) || wr_dat[i] !== exp_pat(v.sel, v.base, i)) bad++;
    chk({tag, "_wr_seq"}, 64'(bad), 64'd0);
    chk({tag, "_wd3"}, 64'(wr_dat[3]), 64'(v.wd3));
    chk({tag, "_wd31"}, 64'(wr_dat[31]), 64'(v.wd31));
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat, pulses, seen;
    vec_t v;

    //       sel   base            skip  corrupt         lat pass ei ec   wd3            wd31
    vecs[0] = '{2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000, 33, 1'b1, 0, 0,  32'h0000_0003, 32'h0000_001F};
    vecs[1] = '{2'd2, 32'h0000_0010, 1'b0, 32'h0000_0000, 66, 1'b1, 0, 0,  32'hFFFF_FFEC, 32'hFFFF_FFD0};
    vecs[2] = '{2'd2, 32'h0000_0010, 1'b0, 32'h0002_0020, 66, 1'b0, 5, 2,  32'hFFFF_FFEC, 32'hFFFF_FFD0};
    vecs[3] = '{2'd1, 32'hA5A5_0F0F, 1'b0, 32'h0000_0000, 66, 1'b1, 0, 0,  32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vecs[4] = '{2'd3, 32'h8000_0001, 1'b0, 32'h8000_0000, 66, 1'b0, 31, 1, 32'h0000_000C, 32'hC000_0000};
    vecs[5] = '{2'd0, 32'hFFFF_FFF0, 1'b0, 32'h0000_0001, 66, 1'b0, 0, 1,  32'hFFFF_FFF3, 32'h0000_000F};
    vecs[6] = '{2'd1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 66, 1'b0, 0, 32, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; start = 1'b0; abort = 1'b0; skip_verify = 1'b0;
    pattern_sel = 2'd0; base_value = '0; corrupt = '0; wr_n = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {index, writeData, writeEnable, busy, done, pass, err_index, err_count},
        64'd0);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) do_row(vecs[r], $sformatf("row%0d", r));

    // Abort during FILL cycle 10.
    corrupt = '0;
    wr_n = 0;
    @(negedge clk);
    pattern_sel = 2'd0; base_value = '0; skip_verify = 1'b0; start = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    chk("abort_pre_index", 64'(index), 64'd10);
    chk("abort_pre_we", 64'(writeEnable), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_we", 64'(writeEnable), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_results", {pass, err_index, err_count}, 64'd0);
    chk("abort_write_count", 64'(wr_n), 64'd11);
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    v = '{2'd0, 32'h0, 1'b0, 32'h0, 66, 1'b1, 0, 0, 32'h3, 32'h1F};
    do_row(v, "after_abort");

    // abort and start together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_start_idle_we", {busy, writeEnable}, 64'd0);

    // start pulses during FILL and during DONE are ignored.
    @(negedge clk);
    pattern_sel = 2'd1; base_value = 32'h3C; skip_verify = 1'b0; start = 1'b1;
    pulses = 0; seen = -1;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
      if (seen > 0 && n == seen + 1) start = 1'b0;
      if (done) begin
        pulses++;
        if (seen < 0) begin
          seen = n;
          start = 1'b1;
        end
      end
    end
    chk("restart_done_pulses", 64'(pulses), 64'd1);
    chk("restart_latency", 64'(seen), 64'd66);
    chk("restart_idle_after", {busy, writeEnable}, 64'd0);
    chk("restart_pass", 64'(pass), 64'd1);

    // rst mid-VERIFY overrides abort and start.
    run_sweep(2'd2, 32'h55, 1'b0, lat);
    chk("pre_rst_pass", 64'(pass), 64'd1);
    @(negedge clk);
    pattern_sel = 2'd0; base_value = 32'h0; skip_verify = 1'b0; start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    chk("pre_rst_busy", {busy, writeEnable}, 64'h2);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    chk("rst_mid_index", 64'(index), 64'd0);
    chk("rst_mid_wdata", 64'(writeData), 64'd0);
    chk("rst_mid_ctrl", {writeEnable, busy, done, pass}, 64'd0);
    chk("rst_mid_err", {err_index, err_count}, 64'd0);
    @(negedge clk);
    chk("rst_stays_idle", 64'(busy), 64'd0);
    v = '{2'd3, 32'h1, 1'b1, 32'h0, 33, 1'b1, 0, 0, 32'h8, 32'h8000_0000};
    do_row(v, "after_rst_rotl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
